muldiv_unit: RTL and testbench

Multi-cycle signed multiply/divide/remainder execution unit for the RISC-V core. It sits in the execute stage beside the single-cycle ALU and takes the same 4-bit operation code from ALU control. It accepts the MUL, DIV and REM codes with two register operands. It then holds the pipeline via `busy` and returns a registered result with a one-cycle `done` pulse.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - ALU control op codes accepted by the unit
//   - FSM state enum
//   - fill/MSB constants that build the divide special-case results at any XLEN
//   - op_valid(): true for the op codes the unit executes
package muldiv_pkg;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_REM = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // DIV by zero returns every bit set
  localparam logic DIV0_QUOT_FILL = 1'b1;
  // most-negative / -1: quotient is the most-negative value (MSB set, rest clear)
  localparam logic OVF_QUOT_MSB   = 1'b1;
  // most-negative REM -1 is zero
  localparam logic OVF_REM_FILL   = 1'b0;

  function automatic logic op_valid(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative datapath.
//   part      : 2*XLEN partial value (accumulator for MUL, remainder in low bits for DIV)
//   operand   : multiplicand magnitude (MUL) or divisor magnitude (DIV)
//   in_bit    : current multiplier bit (MUL) or next dividend bit (DIV)
//   div_mode  : 1 = restoring divide step, 0 = shift-add multiply step
//   part_next : partial value after this iteration
//   q_bit     : quotient bit produced (DIV), 0 for MUL
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] part,
  input  logic [XLEN-1:0]   operand,
  input  logic              in_bit,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] part_next,
  output logic              q_bit
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // Single multiply or restoring-divide iteration
  always_comb begin
    // MUL: add multiplicand into the upper half, then shift the whole accumulator right
    sum_s     = {1'b0, part[2*XLEN-1:XLEN]} + {1'b0, (in_bit ? operand : {XLEN{1'b0}})};
    // DIV: bring in the next dividend bit and trial-subtract the divisor
    shifted_s = {part[XLEN-1:0], in_bit};
    diff_s    = shifted_s - {1'b0, operand};
    if (div_mode) begin
      q_bit     = ~diff_s[XLEN];
      part_next = {{(XLEN-1){1'b0}}, (diff_s[XLEN] ? shifted_s : diff_s)};
    end else begin
      q_bit     = 1'b0;
      part_next = {sum_s, part[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed MUL / DIV / REM execution unit.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start, op     : request and ALU op code (MUL/DIV/REM), sampled while not busy
//   a, b          : rs1 / rs2 operands, two's complement
//   flush         : synchronous cancel; returns to IDLE without done
//   busy          : operation in flight, upstream holds the stage
//   done          : one-cycle pulse, result valid
//   result        : registered result, changes only on the edge entering DONE
// Optional build macro MULDIV_FAST_MUL_EN: MUL becomes a single-cycle product
// captured on the accept edge; DIV/REM keep the iterative path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MOST_NEG = {OVF_QUOT_MSB, {(XLEN-1){1'b0}}};

  state_e            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] part_r, part_next_s;
  logic [XLEN-1:0]   shreg_r, opnd_r;
  logic              div_mode_r, rem_sel_r, neg_q_r, neg_r_r;
  logic              busy_r, done_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s, is_mul_s, is_div_s, is_rem_s;
  logic              special_s, direct_s, in_bit_s, q_bit_s, last_iter_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, special_res_s, direct_res_s, fix_res_s;

  assign is_mul_s    = (op == OP_MUL);
  assign is_div_s    = (op == OP_DIV);
  assign is_rem_s    = (op == OP_REM);
  assign accept_s    = start && op_valid(op) && !flush &&
                       ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign a_mag_s     = a[XLEN-1] ? (~a + ONE_X) : a;
  assign b_mag_s     = b[XLEN-1] ? (~b + ONE_X) : b;
  assign last_iter_s = (cnt_r == CNT_W'(XLEN-1));
  // divide consumes dividend MSB-first, multiply consumes multiplier LSB-first
  assign in_bit_s    = div_mode_r ? shreg_r[XLEN-1] : shreg_r[0];

  muldiv_step #(.XLEN(XLEN)) u_step (
    .part      (part_r),
    .operand   (opnd_r),
    .in_bit    (in_bit_s),
    .div_mode  (div_mode_r),
    .part_next (part_next_s),
    .q_bit     (q_bit_s)
  );

  // Divide special cases (by zero, most-negative / -1) and results that skip CALC
  always_comb begin
    special_s = 1'b0;
    if (is_div_s || is_rem_s) begin
      special_s = (b == {XLEN{1'b0}}) || ((a == MOST_NEG) && (b == {XLEN{1'b1}}));
    end else begin
      special_s = 1'b0;
    end
    if (b == {XLEN{1'b0}}) begin
      special_res_s = is_div_s ? {XLEN{DIV0_QUOT_FILL}} : a;
    end else begin
      special_res_s = is_div_s ? MOST_NEG : {XLEN{OVF_REM_FILL}};
    end
`ifdef MULDIV_FAST_MUL_EN
    direct_s     = special_s || is_mul_s;
    direct_res_s = is_mul_s ? (a * b) : special_res_s;
`else
    direct_s     = special_s;
    direct_res_s = special_res_s;
`endif
  end

  // Sign correction applied in FIX
  always_comb begin
    if (div_mode_r) begin
      if (rem_sel_r) begin
        fix_res_s = neg_r_r ? (~part_r[XLEN-1:0] + ONE_X) : part_r[XLEN-1:0];
      end else begin
        fix_res_s = neg_q_r ? (~shreg_r + ONE_X) : shreg_r;
      end
    end else begin
      // low half of the negated product equals the negated low half
      fix_res_s = neg_q_r ? (~part_r[XLEN-1:0] + ONE_X) : part_r[XLEN-1:0];
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_next_s = direct_s ? ST_DONE : ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_iter_s) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_FIX:  state_next_s = ST_DONE;
      default: state_next_s = ST_IDLE;
    endcase
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Iteration counter; wraps back to 0 after the last CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s || flush) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_CALC) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Operand latch on accept and one datapath iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_r     <= {(2*XLEN){1'b0}};
      shreg_r    <= {XLEN{1'b0}};
      opnd_r     <= {XLEN{1'b0}};
      div_mode_r <= 1'b0;
      rem_sel_r  <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
    end else if (accept_s) begin
      part_r     <= {(2*XLEN){1'b0}};
      shreg_r    <= is_mul_s ? b_mag_s : a_mag_s;
      opnd_r     <= is_mul_s ? a_mag_s : b_mag_s;
      div_mode_r <= !is_mul_s;
      rem_sel_r  <= is_rem_s;
      neg_q_r    <= a[XLEN-1] ^ b[XLEN-1];
      neg_r_r    <= a[XLEN-1];
    end else if (state_r == ST_CALC) begin
      part_r     <= part_next_s;
      shreg_r    <= div_mode_r ? {shreg_r[XLEN-2:0], q_bit_s} : {1'b0, shreg_r[XLEN-1:1]};
    end
  end

  // Registered outputs derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      busy_r <= (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
      done_r <= (state_next_s == ST_DONE);
      if (accept_s && direct_s) begin
        result_r <= direct_res_s;
      end else if ((state_r == ST_FIX) && !flush) begin
        result_r <= fix_res_s;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  localparam logic [3:0] T_MUL = 4'b0010;
  localparam logic [3:0] T_DIV = 4'b0011;
  localparam logic [3:0] T_REM = 4'b0100;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  int          tests_run = 0;
  int          tests_failed = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called at a negedge: present a request for the next rising edge (cycle 0)
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the done cycle (-1 on timeout) at that cycle's negedge, and counts busy glitches
  task automatic wait_done(output int lat, output int berr);
    lat = -1; berr = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (busy !== 1'b0) berr++;
        lat = c;
        break;
      end else if (busy !== 1'b1) begin
        berr++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 4'b0000; a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] ta [3] = '{32'd7, 32'hFFFFFFFB, 32'h80000000};
    logic [31:0] tb [3] = '{32'hFFFFFFFD, 32'hFFFFFFFA, 32'hFFFFFFFF};
    logic [31:0] te [3] = '{32'hFFFFFFEB, 32'd30, 32'h80000000};
    int lat, berr;
    for (int i = 0; i < 3; i++) begin
      issue(T_MUL, ta[i], tb[i]);
      wait_done(lat, berr);
      tests_run++; if (lat !== MUL_LAT) begin tests_failed++; $display("FAIL mul%0d_latency got %0d want %0d", i, lat, MUL_LAT); end
      tests_run++; if (result !== te[i]) begin tests_failed++; $display("FAIL mul%0d_result got %h want %h", i, result, te[i]); end
      tests_run++; if (berr !== 0) begin tests_failed++; $display("FAIL mul%0d_busy bad cycles %0d want 0", i, berr); end
    end
  endtask

  task automatic test_divrem();
    logic [3:0]  to [6] = '{T_DIV, T_REM, T_DIV, T_REM, T_DIV, T_REM};
    logic [31:0] ta [6] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100, 32'd7, 32'hFFFFFFF9};
    logic [31:0] tb [6] = '{32'd3, 32'd3, 32'd7, 32'd7, 32'hFFFFFFFE, 32'd2};
    logic [31:0] te [6] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF};
    int lat, berr;
    for (int i = 0; i < 6; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(lat, berr);
      tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL divrem%0d_latency got %0d want 34", i, lat); end
      tests_run++; if (result !== te[i]) begin tests_failed++; $display("FAIL divrem%0d_result got %h want %h", i, result, te[i]); end
      tests_run++; if (berr !== 0) begin tests_failed++; $display("FAIL divrem%0d_busy bad cycles %0d want 0", i, berr); end
    end
  endtask

  task automatic test_special();
    logic [3:0]  to [4] = '{T_DIV, T_DIV, T_REM, T_REM};
    logic [31:0] ta [4] = '{32'd5, 32'h80000000, 32'h80000000, 32'd5};
    logic [31:0] tb [4] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] te [4] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'd5};
    int lat, berr;
    for (int i = 0; i < 4; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(lat, berr);
      tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL special%0d_latency got %0d want 1", i, lat); end
      tests_run++; if (result !== te[i]) begin tests_failed++; $display("FAIL special%0d_result got %h want %h", i, result, te[i]); end
    end
  endtask

  task automatic test_invalid_op();
    int ndone = 0, nbusy = 0;
    issue(4'b0001, 32'd9, 32'd3);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
    end
    tests_run++; if (ndone !== 0) begin tests_failed++; $display("FAIL invalid_done got %0d pulses want 0", ndone); end
    tests_run++; if (nbusy !== 0) begin tests_failed++; $display("FAIL invalid_busy got %0d cycles want 0", nbusy); end
    tests_run++; if (result !== 32'd5) begin tests_failed++; $display("FAIL invalid_result got %h want 5", result); end
  endtask

  task automatic test_flush();
    int ndone = 0, lat, berr;
    issue(T_DIV, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got %b want 0", busy); end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    tests_run++; if (ndone !== 0) begin tests_failed++; $display("FAIL flush_done got %0d pulses want 0", ndone); end
    tests_run++; if (result !== 32'd5) begin tests_failed++; $display("FAIL flush_result got %h want 5", result); end
    issue(T_DIV, 32'd100, 32'd7);
    wait_done(lat, berr);
    tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL postflush_latency got %0d want 34", lat); end
    tests_run++; if (result !== 32'd14) begin tests_failed++; $display("FAIL postflush_result got %h want 14", result); end
  endtask

  task automatic test_ignored_start();
    int ndone = 0, first = -1;
    logic [31:0] mid = 32'h0;
    issue(T_DIV, 32'hFFFFFFEC, 32'd3);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
      end
      if (c == 5) begin op = T_MUL; a = 32'd1; b = 32'd1; start = 1'b1; end
      if (c == 6) start = 1'b0;
      if (c == 20) mid = result;
    end
    tests_run++; if (ndone !== 1) begin tests_failed++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
    tests_run++; if (first !== 34) begin tests_failed++; $display("FAIL ignored_latency got %0d want 34", first); end
    tests_run++; if (mid !== 32'd14) begin tests_failed++; $display("FAIL result_held_midcalc got %h want 0000000e", mid); end
    tests_run++; if (result !== 32'hFFFFFFFA) begin tests_failed++; $display("FAIL ignored_result got %h want fffffffa", result); end
  endtask

  task automatic test_back_to_back();
    int lat, berr;
    issue(T_DIV, 32'd100, 32'd7);
    wait_done(lat, berr);
    tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL b2b_first_latency got %0d want 34", lat); end
    tests_run++; if (result !== 32'd14) begin tests_failed++; $display("FAIL b2b_first_result got %h want 14", result); end
    issue(T_REM, 32'hFFFFFFEC, 32'd3);
    wait_done(lat, berr);
    tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL b2b_second_latency got %0d want 34", lat); end
    tests_run++; if (result !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL b2b_second_result got %h want fffffffe", result); end
    tests_run++; if (berr !== 0) begin tests_failed++; $display("FAIL b2b_busy bad cycles %0d want 0", berr); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    issue(T_DIV, 32'hFFFFFFEC, 32'd3);
    for (int c = 1; c <= 15; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done got %b want 0", done); end
    tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL midrst_result got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    tests_run++; if (ndone !== 0) begin tests_failed++; $display("FAIL midrst_late_done got %0d pulses want 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divrem();
    test_special();
    test_invalid_op();
    test_flush();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
